// File: rtl/led_pattern_if.sv
// Control and status bundle between the board sequencer and the LED pattern driver.
// The address carries one spare bit so out-of-range channel indices are representable and dropped.
interface led_pattern_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_W    = 8,
  parameter int ADDR_W   = $clog2(NUM_LEDS) + 1
);
  logic                enable;
  logic                mode_wr;
  logic [1:0]          mode;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PWM_W-1:0]    wr_data;
  logic [NUM_LEDS-1:0] led;
  logic                bank_enable;
  logic                tick;

  modport master (
    output enable, mode_wr, mode, wr_en, wr_addr, wr_data,
    input  led, bank_enable, tick
  );

  modport slave (
    input  enable, mode_wr, mode, wr_en, wr_addr, wr_data,
    output led, bank_enable, tick
  );
endinterface

// File: rtl/led_pattern_driver.sv
// Board LED driver: binary count, chase, per-channel PWM and breathe patterns,
// stepped by a free-running prescaler and gated by a run enable.
module led_pattern_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int PRESCALE_W = 18,
  parameter int PWM_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  led_pattern_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_LEDS) + 1;

  localparam logic [1:0] MODE_BINARY  = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] presc;
  logic [NUM_LEDS-1:0]   pat;
  logic [NUM_LEDS-1:0]   chase;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PWM_W-1:0]      level;
  logic                  dir_up;
  logic [PWM_W-1:0]      duty   [NUM_LEDS];
  logic [PWM_W-1:0]      shadow [NUM_LEDS];

  logic                  step;
  logic                  period_end;
  logic [NUM_LEDS-1:0]   pwm_on;
  logic [NUM_LEDS-1:0]   breathe_on;
  logic [NUM_LEDS-1:0]   led_p0;
  logic [NUM_LEDS-1:0]   led_p1;
  logic                  tick_p1;
  logic                  bank_en;

  // Saturating up/down walk of the breathe level: returns {dir_up, level}.
  // At either end the direction flips and the level holds for one step.
  function automatic logic [PWM_W:0] breathe_next(input logic [PWM_W-1:0] lvl,
                                                  input logic             up);
    logic [PWM_W:0] res;
    if (up) begin
      if (lvl == {PWM_W{1'b1}}) res = {1'b0, lvl};
      else                      res = {1'b1, lvl + 1'b1};
    end else begin
      if (lvl == '0)            res = {1'b1, lvl};
      else                      res = {1'b0, lvl - 1'b1};
    end
    return res;
  endfunction

  // A mode write clears the counters on the same edge, so it also suppresses the step.
  assign step       = bus.enable && (presc == {PRESCALE_W{1'b1}}) && !bus.mode_wr;
  assign period_end = bus.enable && (pwm_cnt == {PWM_W{1'b1}}) && !bus.mode_wr;

  // Stage p0: LED pattern selected from current internal state
  always_comb begin
    pwm_on     = '0;
    breathe_on = '0;
    led_p0     = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_on[i]     = (pwm_cnt < shadow[i]);
      breathe_on[i] = (pwm_cnt < level) && (shadow[i] != '0);
    end
    case (mode)
      MODE_BINARY:  led_p0 = pat;
      MODE_CHASE:   led_p0 = chase;
      MODE_PWM:     led_p0 = pwm_on;
      MODE_BREATHE: led_p0 = breathe_on;
      default:      led_p0 = '0;
    endcase
  end

  // Stage p1: registered LED drive, step pulse and pattern state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode    <= MODE_BINARY;
      presc   <= '0;
      pat     <= '0;
      chase   <= NUM_LEDS'(1);
      pwm_cnt <= '0;
      level   <= '0;
      dir_up  <= 1'b1;
      led_p1  <= '0;
      tick_p1 <= 1'b0;
      bank_en <= 1'b0;
    end else begin
      bank_en <= 1'b1;
      tick_p1 <= step;
      if (bus.enable) led_p1 <= led_p0;
      if (bus.mode_wr) begin
        mode    <= bus.mode;
        presc   <= '0;
        pat     <= '0;
        chase   <= NUM_LEDS'(1);
        pwm_cnt <= '0;
        level   <= '0;
        dir_up  <= 1'b1;
      end else if (bus.enable) begin
        presc   <= presc + 1'b1;
        pwm_cnt <= pwm_cnt + 1'b1;
        if (step) begin
          pat             <= pat + 1'b1;
          chase           <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
          {dir_up, level} <= breathe_next(level, dir_up);
        end
      end
    end
  end

  // Duty values reach the comparators only at a PWM period boundary, so a
  // mid-period write never produces a runt pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) duty[i] <= bus.wr_data;
        if (period_end) shadow[i] <= duty[i];
      end
    end
  end

  assign bus.led         = led_p1;
  assign bus.tick        = tick_p1;
  assign bus.bank_enable = bank_en;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver: binary, chase, freeze, PWM, reset and breathe.
module tb_led_pattern_driver;
  localparam int NUM_LEDS   = 4;
  localparam int PRESCALE_W = 2;
  localparam int PWM_W      = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   on_cnt [NUM_LEDS];

  always #5 clk = ~clk;

  led_pattern_if #(.NUM_LEDS(NUM_LEDS), .PWM_W(PWM_W)) bus ();

  led_pattern_driver #(
    .NUM_LEDS  (NUM_LEDS),
    .PRESCALE_W(PRESCALE_W),
    .PWM_W     (PWM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Clocks until Tick is seen, bounded; an expired bound returns 20 and fails the gap check.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (!bus.tick && n < 20);
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.mode_wr = 1'b1;
    bus.mode    = m;
    tick_clk();
    bus.mode_wr = 1'b0;
  endtask

  task automatic write_duty(input logic [2:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick_clk();
    bus.wr_en   = 1'b0;
  endtask

  // Counts on-cycles per channel over 16 clocks; optionally writes duty[1]=4 and an
  // out-of-range channel mid-window.
  task automatic run_window(input bit do_write);
    for (int c = 0; c < NUM_LEDS; c++) on_cnt[c] = 0;
    for (int i = 0; i < 16; i++) begin
      if (do_write && i == 4) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'd4;
      end
      if (do_write && i == 5) begin
        bus.wr_addr = 3'd5; bus.wr_data = 4'd15;
      end
      if (do_write && i == 6) bus.wr_en = 1'b0;
      tick_clk();
      for (int c = 0; c < NUM_LEDS; c++) on_cnt[c] += int'(bus.led[c]);
    end
  endtask

  initial begin
    int n;
    logic [3:0] ch_exp [4];
    int         pwm_a  [4];
    int         pwm_c  [4];
    int         br_exp [10];
    ch_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pwm_a  = '{0, 1, 8, 15};
    pwm_c  = '{0, 4, 8, 15};
    br_exp = '{0, 5, 10, 15, 12, 9, 6, 3, 0, 5};

    rst = 1'b1;
    bus.enable = 1'b1; bus.mode_wr = 1'b0; bus.mode = 2'd0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    tick_clk();
    tick_clk();
    check("rst_led", bus.led, 4'd0);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_bank", bus.bank_enable, 1'b0);

    // Binary count: Tick every 4 clocks, LED follows pat and wraps after 16 steps
    rst = 1'b0;
    tick_clk();
    check("bank_first_clk", bus.bank_enable, 1'b1);
    check("bin_led_start", bus.led, 4'd0);
    wait_tick(n);
    check("bin_first_gap", n, 3);
    for (int k = 1; k <= 16; k++) begin
      tick_clk();
      check($sformatf("bin_led_%0d", k), bus.led, 32'(k % 16));
      wait_tick(n);
      check($sformatf("bin_gap_%0d", k), n, 3);
    end

    // Chase
    set_mode(2'd1);
    tick_clk();
    check("chase_start", bus.led, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check($sformatf("chase_gap_%0d", i), n, 3);
      tick_clk();
      check($sformatf("chase_led_%0d", i), bus.led, ch_exp[i]);
      check($sformatf("chase_onehot_%0d", i), 32'($onehot(bus.led)), 1);
    end

    // Freeze in chase mode, then resume from the same position
    wait_tick(n);
    tick_clk();
    check("pre_freeze_led", bus.led, 4'b0010);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      check($sformatf("freeze_led_%0d", i), bus.led, 4'b0010);
      check($sformatf("freeze_tick_%0d", i), bus.tick, 1'b0);
    end
    bus.enable = 1'b1;
    wait_tick(n);
    check("resume_gap", n, 3);
    tick_clk();
    check("resume_led", bus.led, 4'b0100);

    // ModeWr while frozen clears the counters but LED holds until re-enabled
    bus.enable = 1'b0;
    repeat (3) tick_clk();
    set_mode(2'd1);
    tick_clk();
    check("frozen_modewr_led", bus.led, 4'b0100);
    bus.enable = 1'b1;
    tick_clk();
    check("modewr_cleared_chase", bus.led, 4'b0001);
    wait_tick(n);
    check("modewr_cleared_presc", n, 3);
    tick_clk();
    check("modewr_next_step", bus.led, 4'b0010);

    // PWM: duties load at the period boundary; mid-period write shows in the next period
    write_duty(3'd0, 4'd0);
    write_duty(3'd1, 4'd1);
    write_duty(3'd2, 4'd8);
    write_duty(3'd3, 4'd15);
    set_mode(2'd2);
    repeat (16) tick_clk();
    run_window(1'b0);
    for (int c = 0; c < NUM_LEDS; c++)
      check($sformatf("pwm_a_led%0d", c), on_cnt[c], pwm_a[c]);
    run_window(1'b1);
    for (int c = 0; c < NUM_LEDS; c++)
      check($sformatf("pwm_b_led%0d", c), on_cnt[c], pwm_a[c]);
    run_window(1'b0);
    for (int c = 0; c < NUM_LEDS; c++)
      check($sformatf("pwm_c_led%0d", c), on_cnt[c], pwm_c[c]);

    // Asynchronous reset mid-PWM
    tick_clk();
    check("pwm_pre_reset", bus.led, 4'b1110);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", bus.led, 4'd0);
    check("async_rst_bank", bus.bank_enable, 1'b0);
    check("async_rst_tick", bus.tick, 1'b0);
    tick_clk();
    rst = 1'b0;
    tick_clk();
    check("post_rst_bank", bus.bank_enable, 1'b1);
    check("post_rst_led", bus.led, 4'd0);
    wait_tick(n);
    check("post_rst_gap", n, 3);
    tick_clk();
    check("post_rst_binary", bus.led, 4'd1);

    // Breathe: per-16-clock on-counts trace level 0..15, hold, 15..0, hold; duty[2]=0 stays dark
    write_duty(3'd0, 4'd1);
    write_duty(3'd1, 4'd1);
    write_duty(3'd2, 4'd0);
    write_duty(3'd3, 4'd1);
    repeat (16) tick_clk();
    set_mode(2'd3);
    for (int j = 0; j < 10; j++) begin
      run_window(1'b0);
      check($sformatf("breathe_led0_w%0d", j), on_cnt[0], br_exp[j]);
      check($sformatf("breathe_led2_w%0d", j), on_cnt[2], 0);
      check($sformatf("breathe_led3_w%0d", j), on_cnt[3], br_exp[j]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
